// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl
//   Front end for the servo PWM generator. Two requesters supply target
//   positions: req0 (host/SPI) has priority over req1 (local strategy FSM).
//   The accepted target is clamped to MAX_POS. The control word then slews
//   toward it by at most 'step' once per PWM frame, so the servo never
//   jumps to a new position.
//
// Ports
//   clk, reset_n            : clock; asynchronous active-low reset
//   enable                  : 1 = ramp and accept requests; 0 = freeze
//   step[15:0]              : largest change of control per frame (0 acts as 1)
//   req0_valid/pos/ready    : high-priority request handshake
//   req1_valid/pos/ready    : low-priority request handshake
//   control[31:0]           : zero-extended position sent to the PWM generator
//   busy                    : high while a move is in progress
//   owner                   : requester of the current or last accepted target
//   done                    : one-cycle pulse when control reaches the target
module servo_ramp_ctrl #(
    parameter int FRAME_CLKS = 1_000_000,
    parameter int MAX_POS    = 50_000,
    parameter int CENTER_POS = 25_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] step,
    input  logic        req0_valid,
    input  logic [15:0] req0_pos,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_pos,
    output logic        req1_ready,
    output logic [31:0] control,
    output logic        busy,
    output logic        owner,
    output logic        done
);

    typedef enum logic {S_IDLE, S_MOVING} state_t;

    localparam logic [19:0] LP_LAST   = 20'(FRAME_CLKS - 1);
    localparam logic [15:0] LP_MAX    = 16'(MAX_POS);
    localparam logic [15:0] LP_CENTER = 16'(CENTER_POS);

    state_t      r_state, w_state_nxt;
    logic [19:0] r_cnt;
    logic [15:0] r_ctrl, w_ctrl_nxt;
    logic [15:0] r_tgt, w_tgt_nxt;
    logic        r_owner, w_owner_nxt;
    logic        r_done, w_done_nxt;

    logic        w_tick;
    logic [15:0] w_step;
    logic [16:0] w_diff;
    logic        w_acc0, w_acc1;

    // Frame counter free-runs regardless of enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            r_cnt <= '0;
        else if (r_cnt == LP_LAST) r_cnt <= '0;
        else                     r_cnt <= r_cnt + 20'd1;
    end

    assign w_tick = (r_cnt == LP_LAST);
    assign w_step = (step == 16'd0) ? 16'd1 : step;
    assign w_diff = (r_tgt >= r_ctrl) ? ({1'b0, r_tgt} - {1'b0, r_ctrl})
                                      : ({1'b0, r_ctrl} - {1'b0, r_tgt});

    // Ready is gated by reset_n so neither requester sees ready during reset.
    assign req0_ready = reset_n & enable & (r_state == S_IDLE || r_state == S_MOVING);
    assign req1_ready = reset_n & enable & (r_state == S_IDLE) & ~req0_valid;
    assign w_acc0     = req0_valid & req0_ready;
    assign w_acc1     = req1_valid & req1_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ctrl  <= LP_CENTER;
            r_tgt   <= LP_CENTER;
            r_owner <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_tgt   <= w_tgt_nxt;
            r_owner <= w_owner_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = r_ctrl;
        w_tgt_nxt   = r_tgt;
        w_owner_nxt = r_owner;
        w_done_nxt  = 1'b0;

        // Ramp step always uses the target held before this edge; a target
        // accepted in the same cycle only takes effect from the next tick.
        if (r_state == S_MOVING && enable && w_tick) begin
            if (w_diff <= {1'b0, w_step}) begin
                w_ctrl_nxt  = r_tgt;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end else if (r_tgt > r_ctrl) begin
                // diff > step, so control + step stays below target (<= MAX).
                w_ctrl_nxt = r_ctrl + w_step;
            end else begin
                w_ctrl_nxt = r_ctrl - w_step;
            end
        end

        // Acceptance overrides the ramp's state decision: a new target keeps
        // the block MOVING even if the old target was just reached.
        if (w_acc0) begin
            w_tgt_nxt   = (req0_pos > LP_MAX) ? LP_MAX : req0_pos;
            w_owner_nxt = 1'b0;
            w_state_nxt = S_MOVING;
        end else if (w_acc1) begin
            w_tgt_nxt   = (req1_pos > LP_MAX) ? LP_MAX : req1_pos;
            w_owner_nxt = 1'b1;
            w_state_nxt = S_MOVING;
        end
    end

    assign control = {16'd0, r_ctrl};
    assign busy    = (r_state == S_MOVING);
    assign owner   = r_owner;
    assign done    = r_done;

endmodule

// File: doc/servo_ramp_ctrl.md
Name: servo_ramp_ctrl

Overview:
- Front-end controller for the servo PWM generator. Arbitrates target-position requests from two requesters: port 0, the host/SPI command path, has high priority; port 1, the local strategy FSM, has low priority.
- Ramps the 32-bit control word toward the accepted target by a bounded step once per 20 ms PWM frame, so the servo slews instead of jumping.
- Drives the PWM generator's control input directly and reports busy/done status.

Parameters:
- FRAME_CLKS, 1_000_000, clocks per PWM frame (20 ms at 50 MHz); benches override to 100.
- MAX_POS, 50_000, largest legal control value (2 ms pulse width minus 1 ms base).
- CENTER_POS, 25_000, control value after reset (mid travel).

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = ramping and request acceptance allowed; 0 = freeze
- step  in  16  maximum change of control per frame; 0 is treated as 1
- req0_valid  in  1  high-priority request valid
- req0_pos  in  16  high-priority target position
- req0_ready  out  1  high-priority request accepted this cycle when valid&ready
- req1_valid  in  1  low-priority request valid
- req1_pos  in  16  low-priority target position
- req1_ready  out  1  low-priority request accepted this cycle when valid&ready
- control  out  32  control word to PWM generator, zero-extended 16-bit position
- busy  out  1  high while in MOVING
- owner  out  1  requester of the current or last accepted target (0/1)
- done  out  1  one-cycle pulse when control reaches target

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; control=CENTER_POS; target=CENTER_POS.
  - frame counter=0; busy=0; done=0; owner=0.
  - Both ready outputs are 0 while reset_n=0.
- Frame counter:
  - 20-bit counter runs 0..FRAME_CLKS-1, then wraps to 0; it counts regardless of enable.
  - frame_tick is an internal 1-cycle pulse in the cycle the counter equals FRAME_CLKS-1.
- Ready (combinational from state and enable):
  - req0_ready = enable & (state==IDLE | state==MOVING).
  - req1_ready = enable & (state==IDLE) & ~req0_valid.
- Acceptance and arbitration:
  - A request is accepted on a rising clk edge with valid&ready.
  - If both requesters are valid in IDLE, only req0 is accepted; req1 stays pending, and its valid must stay asserted until accepted.
  - Accepting a request sets target=min(pos, MAX_POS), sets owner, and sets state=MOVING.
  - req0 accepted during MOVING pre-empts the move: the target is replaced and owner=0; control does not jump.
- State transitions:
  - IDLE -> MOVING on acceptance.
  - MOVING -> IDLE on the frame_tick where control reaches target.
  - Accepting a target equal to the current control gives MOVING, then done on the next frame_tick.
- Ramp, evaluated on frame_tick in MOVING with enable=1:
  - Let s = (step==0) ? 1 : step, and d = |target-control| (17-bit unsigned compare).
  - If d<=s: control=target, done=1 for that cycle, state=IDLE.
  - Otherwise: control = control ± s, moving toward target.
  - control never leaves 0..MAX_POS.
- Simultaneous events: acceptance and frame_tick in the same cycle. The new target is registered and the ramp step uses the old target; the new target applies from the next tick.
- enable=0:
  - Ticks are ignored, control holds, and state holds (busy stays 1 if MOVING).
  - Ramping resumes on the first tick after enable returns to 1.
- control changes only in the cycle after a frame_tick, so pulse width is never altered mid-frame relative to the tick.
- Reset mid-move returns control to CENTER_POS immediately.

Test Plan:
All cases use FRAME_CLKS=100.
1. Reset with reset_n=0 for 3 cycles -> control=25000, busy=0, done=0, req0_ready=req1_ready=0 while in reset.
2. step=10000, req1_pos=45000 accepted in IDLE -> control 35000, then 45000 on the next two frame_ticks; done pulses 1 cycle on the second tick; owner=1; busy falls with done.
3. req0_pos=5000 and req1_pos=40000 both valid in IDLE -> req0 accepted, req1_ready=0 until return to IDLE; afterwards req1 is accepted and control ramps to 40000.
4. step=1000, req1 to 45000; after 3 ticks (control=28000), req0_pos=20000 pre-empts -> owner=0, control 27000, 26000, …, 20000; exactly one done pulse in total.
5. req0_pos=60000 -> target clamped to 50000; with step=0, control increments by 1 per tick; control never exceeds 50000.
6. enable=0 during MOVING for 5 frames -> control constant, busy=1, both ready=0; enable=1 -> ramp resumes at the next tick. Separately, reset_n pulse mid-move -> control=25000 asynchronously.
